// File: rtl/sys_leds_uart_dumper.sv
// -----------------------------------------------------------------------------
// sys_leds_uart_dumper
//
// Board-side reader for the processor front-panel port. On a start request it
// steps SYS_output_sel through 0..NUM_SEL-1. For each selector it captures the
// 27-bit SYS_leds word and transmits it as one ASCII hex line over an 8N1 UART:
//   <sel hex> ':' <7 hex digits of {1'b0, snapshot}> CR LF
// With DUMP_CHECKSUM_EN defined, each line also carries ' ' and two hex digits
// (XOR of the four bytes of {5'b0, snapshot}) before CR LF.
//
// Optional feature macro: DUMP_CHECKSUM_EN (undefined by default).
//
// Parameters:
//   CLKS_PER_BIT  - SYS_clk cycles per UART bit (>= 2)
//   SETTLE_CYCLES - cycles the selector is held before sampling (>= 1)
//   NUM_SEL       - number of selector values scanned (1..16)
//
// Ports:
//   SYS_clk        in   clock, all state changes on rising edge
//   SYS_reset      in   asynchronous active-high reset
//   start          in   level, sampled in IDLE to begin one dump
//   SYS_leds       in   27-bit LED word for the current selector
//   SYS_output_sel out  8-bit selector driven into the processor
//   uart_tx        out  serial line, idles high
//   busy           out  high from dump acceptance until done
//   done           out  one-cycle pulse at the end of the dump
// -----------------------------------------------------------------------------
module sys_leds_uart_dumper #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_SEL       = 8
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        start,
  input  logic [26:0] SYS_leds,
  output logic [7:0]  SYS_output_sel,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

`ifdef DUMP_CHECKSUM_EN
  localparam int LINE_LEN = 14;
`else
  localparam int LINE_LEN = 11;
`endif

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    SEL_LAST    = 8'(NUM_SEL - 1);
  localparam logic [3:0]    PTR_END     = 4'(LINE_LEN);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_SEND,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_NEXT,
    S_FIN
  } state_t;

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Byte at position ptr of the line for selector sel and snapshot snap.
  function automatic logic [7:0] line_byte(input logic [3:0]  ptr,
                                           input logic [3:0]  sel,
                                           input logic [26:0] snap);
    logic [27:0] w;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0] ck;
`endif
    logic [7:0] b;
    w = {1'b0, snap};
`ifdef DUMP_CHECKSUM_EN
    ck = {5'b0, snap[26:24]} ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
`endif
    case (ptr)
      4'd0:    b = hex_ascii(sel);
      4'd1:    b = 8'h3A;
      4'd2:    b = hex_ascii(w[27:24]);
      4'd3:    b = hex_ascii(w[23:20]);
      4'd4:    b = hex_ascii(w[19:16]);
      4'd5:    b = hex_ascii(w[15:12]);
      4'd6:    b = hex_ascii(w[11:8]);
      4'd7:    b = hex_ascii(w[7:4]);
      4'd8:    b = hex_ascii(w[3:0]);
`ifdef DUMP_CHECKSUM_EN
      4'd9:    b = 8'h20;
      4'd10:   b = hex_ascii(ck[7:4]);
      4'd11:   b = hex_ascii(ck[3:0]);
      4'd12:   b = 8'h0D;
`else
      4'd9:    b = 8'h0D;
`endif
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  state_t      state_q,  state_d;
  logic [7:0]  sel_q,    sel_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [2:0]  bitidx_q, bitidx_d;
  logic [3:0]  ptr_q,    ptr_d;
  logic        tx_q,     tx_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic [26:0] snap_q,   snap_d;
  logic [7:0]  shift_q,  shift_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    bitcnt_d = bitcnt_q;
    bitidx_d = bitidx_q;
    ptr_d    = ptr_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    snap_d   = snap_q;
    shift_d  = shift_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETTLE;
          sel_d    = 8'd0;
          settle_d = '0;
          busy_d   = 1'b1;
        end
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_CAPTURE: begin
        snap_d  = SYS_leds;
        ptr_d   = 4'd0;
        state_d = S_SEND;
      end

      // Load the next character; the start bit is registered here so that
      // uart_tx goes low on the same cycle the FSM enters TX_START.
      S_SEND: begin
        shift_d  = line_byte(ptr_q, sel_q[3:0], snap_q);
        ptr_d    = ptr_q + 1'b1;
        bitcnt_d = '0;
        tx_d     = 1'b0;
        state_d  = S_TX_START;
      end

      S_TX_START: begin
        if (bitcnt_q == BIT_LAST) begin
          bitcnt_d = '0;
          bitidx_d = 3'd0;
          tx_d     = shift_q[0];
          state_d  = S_TX_DATA;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end

      S_TX_DATA: begin
        if (bitcnt_q == BIT_LAST) begin
          bitcnt_d = '0;
          if (bitidx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_TX_STOP;
          end else begin
            bitidx_d = bitidx_q + 1'b1;
            shift_d  = {1'b0, shift_q[7:1]};
            tx_d     = shift_q[1];
          end
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end

      // After the last character of a line go straight to NEXT, so a line
      // costs exactly one SEND cycle per character.
      S_TX_STOP: begin
        if (bitcnt_q == BIT_LAST) begin
          bitcnt_d = '0;
          state_d  = (ptr_q == PTR_END) ? S_NEXT : S_SEND;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end

      S_NEXT: begin
        if (sel_q == SEL_LAST) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          sel_d    = sel_q + 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        sel_d   = 8'd0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q  <= S_IDLE;
      sel_q    <= 8'd0;
      settle_q <= '0;
      bitcnt_q <= '0;
      bitidx_q <= 3'd0;
      ptr_q    <= 4'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      bitcnt_q <= bitcnt_d;
      bitidx_q <= bitidx_d;
      ptr_q    <= ptr_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Snapshot and shift register hold data only; the FSM never consumes them
  // before loading them, so they need no reset.
  always_ff @(posedge SYS_clk) begin
    snap_q  <= snap_d;
    shift_q <= shift_d;
  end

  assign SYS_output_sel = sel_q;
  assign uart_tx        = tx_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_sys_leds_uart_dumper.sv
// -----------------------------------------------------------------------------
// tb_sys_leds_uart_dumper
//
// Testbench for sys_leds_uart_dumper with CLKS_PER_BIT=4, SETTLE_CYCLES=2,
// NUM_SEL=8. Expected line bytes are queued when a dump is requested; a UART
// receiver pops and compares each received character.
// -----------------------------------------------------------------------------
module tb_sys_leds_uart_dumper;
  localparam int CPB    = 4;
  localparam int SETTLE = 2;
  localparam int NSEL   = 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int LEN = 14;
`else
  localparam int LEN = 11;
`endif
  localparam int DUMP_CYC = NSEL * (SETTLE + 2 + LEN * (10 * CPB + 1));
  localparam int NSAMP    = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [26:0] leds;
  logic [7:0]  sel;
  logic        tx;
  logic        busy;
  logic        done;

  int mode = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;

  logic [7:0] exp_q[$];
  string HEX = "0123456789ABCDEF";

  sys_leds_uart_dumper #(
    .CLKS_PER_BIT (CPB),
    .SETTLE_CYCLES(SETTLE),
    .NUM_SEL      (NSEL)
  ) dut (
    .SYS_clk       (clk),
    .SYS_reset     (rst),
    .start         (start),
    .SYS_leds      (leds),
    .SYS_output_sel(sel),
    .uart_tx       (tx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

  function automatic logic [26:0] leds_model(input int m, input logic [7:0] s);
    if (m == 1)                  return 27'h0123456;
    else if (m == 2 && s == 8'd7) return 27'h7FFFFFF;
    else                         return {19'b0, s};
  endfunction

  assign leds = leds_model(mode, sel);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_line(input int s, input logic [26:0] v);
    logic [27:0] w;
    logic [31:0] x;
    logic [7:0]  ck;
    w = {1'b0, v};
    exp_q.push_back(HEX[s]);
    exp_q.push_back(8'h3A);
    for (int d = 6; d >= 0; d--) exp_q.push_back(HEX[int'((w >> (4 * d)) & 28'hF)]);
`ifdef DUMP_CHECKSUM_EN
    x  = {5'b0, v};
    ck = x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
    exp_q.push_back(8'h20);
    exp_q.push_back(HEX[int'(ck >> 4)]);
    exp_q.push_back(HEX[int'(ck & 8'hF)]);
`else
    x  = 32'd0;
    ck = x[7:0];
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_dump();
    for (int s = 0; s < NSEL; s++) push_line(s, leds_model(mode, 8'(s)));
  endtask

  // Requests a dump and waits (bounded) for done, checking acceptance and latency.
  task automatic run_dump(input bit hold, input string tag);
    int  t0;
    bit  seen;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (!hold) start = 1'b0;
    check({tag, "_busy_accept"}, busy, 1'b1);
    check({tag, "_sel_accept"}, sel, 8'd0);
    seen = 1'b0;
    while (!seen && (cyc - t0) < DUMP_CYC + 50) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (seen) check({tag, "_done_latency"}, cyc - t0, DUMP_CYC);
  endtask

  // UART receiver: samples every cycle on the falling edge, checks that each of
  // the 10 bit periods is exactly CPB cycles of a constant level.
  initial begin : uart_monitor
    logic       samp [0:NSAMP-1];
    logic [7:0] rx;
    logic [7:0] e;
    bit         aborted;
    bit         frame_ok;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        samp[0] = tx;
        for (int i = 1; i < NSAMP; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          samp[i] = tx;
        end
        if (!aborted) begin
          frame_ok = 1'b1;
          for (int g = 0; g < 10; g++)
            for (int k = 1; k < CPB; k++)
              if (samp[g * CPB + k] !== samp[g * CPB]) frame_ok = 1'b0;
          if (samp[0] !== 1'b0 || samp[9 * CPB] !== 1'b1) frame_ok = 1'b0;
          for (int b = 0; b < 8; b++) rx[b] = samp[(b + 1) * CPB];
          check("uart_frame", frame_ok, 1'b1);
          check("uart_expected_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("uart_byte", rx, e);
          end
        end
      end
    end
  end

  initial begin : main
    int nd;
    mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_sel", sel, 8'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    // Constant word on every selector.
    nd = n_done;
    mode = 1;
    push_dump();
    run_dump(1'b0, "const");
    repeat (3) @(negedge clk);
    check("const_queue_drained", exp_q.size(), 0);
    check("const_done_pulses", n_done - nd, 1);

    // Each line shows its own selector index.
    nd = n_done;
    mode = 0;
    push_dump();
    run_dump(1'b0, "index");
    repeat (3) @(negedge clk);
    check("index_queue_drained", exp_q.size(), 0);
    check("index_done_pulses", n_done - nd, 1);

    // Start held high: one dump, then a second begins right after done.
    nd = n_done;
    mode = 2;
    push_dump();
    push_dump();
    run_dump(1'b1, "hold");
    check("hold_queue_first_drained", exp_q.size(), NSEL * LEN);
    @(negedge clk);
    check("hold_idle_busy", busy, 1'b0);
    check("hold_idle_done", done, 1'b0);
    @(negedge clk);
    check("hold_restart_busy", busy, 1'b1);
    start = 1'b0;

    // Abandon the second dump mid-character.
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_sel", sel, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("hold_done_pulses", n_done - nd, 1);

    // A fresh dump after reset is complete and correct.
    nd = n_done;
    mode = 0;
    push_dump();
    run_dump(1'b0, "after_reset");
    repeat (3) @(negedge clk);
    check("after_reset_queue_drained", exp_q.size(), 0);
    check("after_reset_done_pulses", n_done - nd, 1);
    check("after_reset_busy_low", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_leds_uart_dumper.md
# sys_leds_uart_dumper

Board-side reader for the processor's front-panel port. On a start pulse it steps `SYS_output_sel` through selector values 0 to NUM_SEL-1. For each value it captures the 27-bit `SYS_leds` word and sends it as an ASCII hex line over an 8N1 UART transmitter. This lets a host dump the instruction, register, ALU, status, DMEM, control, PC and EPC views without watching the LEDs.

## Interface
- `CLKS_PER_BIT`, default 868: SYS_clk cycles per UART bit (100 MHz, 115200 baud); legal range ≥ 2.
- `SETTLE_CYCLES`, default 2: cycles `SYS_output_sel` is held before `SYS_leds` is sampled; legal range ≥ 1.
- `NUM_SEL`, default 8: number of selector values scanned, 1..16.
- `SYS_clk`, input, 1: the single clock. All state changes on its rising edge.
- `SYS_reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: a level sampled high in IDLE begins one dump.
- `SYS_leds`, input, 27: the processor's LED word for the current selector.
- `SYS_output_sel`, output, 8: selector driven into the processor.
- `uart_tx`, output, 1: serial line; idles high.
- `busy`, output, 1: high from dump acceptance until `done`.
- `done`, output, 1: one-cycle pulse after the last stop bit of the dump.

## Operation
- Reset values, applied asynchronously: `uart_tx`=1, `busy`=0, `done`=0, `SYS_output_sel`=0, state IDLE, all counters 0.
- States:
  - IDLE
  - SETTLE
  - CAPTURE
  - SEND (a byte-pointer loop)
  - TX_START, TX_DATA, TX_STOP
  - NEXT
  - FIN
- IDLE → SETTLE when `start`=1. On that edge: sel counter := 0, `busy` := 1. `start` is ignored in every other state.
- SETTLE: holds for SETTLE_CYCLES cycles, then goes to CAPTURE.
- CAPTURE: one cycle. Latches `SYS_leds` into a 27-bit snapshot, then goes to SEND with byte pointer 0.
- Each selector produces one line: ASCII hex digit of sel, `:` (0x3A), then 7 hex digits of {1'b0, snapshot}, MSB digit first, then 0x0D, 0x0A.
  - Hex digits are uppercase; 0-9 map to 0x30-0x39 and A-F to 0x41-0x46.
  - A line is 11 bytes.
- SEND loads the next byte into the shift register and goes to TX_START. After the last byte it goes to NEXT.
- UART character format:
  - Start bit 0 for CLKS_PER_BIT cycles.
  - 8 data bits, LSB first, CLKS_PER_BIT cycles each.
  - Stop bit 1 for CLKS_PER_BIT cycles.
  - No gap between characters other than the one SEND cycle.
- NEXT: if sel = NUM_SEL-1 go to FIN; otherwise increment `SYS_output_sel` and go to SETTLE.
- FIN: `done`=1 for one cycle, `busy` := 0, `SYS_output_sel` := 0, back to IDLE.
- The processor keeps running during a dump, so each line is a snapshot taken at a different cycle. This is intended.
- Reset mid-operation: `uart_tx` goes high immediately, which may truncate a character. The dump is abandoned and no `done` is produced.

## Timing
- The edge that samples `start`=1 puts `SYS_output_sel`=0 and `busy`=1 into effect on the following cycle.
- The first start bit begins SETTLE_CYCLES+2 cycles after the acceptance edge (SETTLE, CAPTURE, SEND).
- Per character: 10·CLKS_PER_BIT + 1 cycles.
- Per line: SETTLE_CYCLES + 2 + bytes·(10·CLKS_PER_BIT+1) cycles, including the NEXT cycle.
- `done` asserts on the cycle after the final stop bit completes.
- Bit-period counter width is clog2(CLKS_PER_BIT). Counters wrap only through explicit reset to 0; none wraps naturally.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - Each line gets ` ` (0x20) and two uppercase hex digits before CR LF.
  - The two digits are the XOR of the four bytes of {5'b0, snapshot}.
  - Line length becomes 14 bytes.
- `DUMP_CHECKSUM_EN` undefined: no checksum logic is present and lines are 11 bytes.

## Test plan
- Reset: assert `SYS_reset` mid-run → `uart_tx`=1, `busy`=0, `done`=0, `SYS_output_sel`=0 in the same cycle. A following `start` produces a complete correct dump.
- Single line: CLKS_PER_BIT=4, SETTLE_CYCLES=2, NUM_SEL=1, `SYS_leds`=27'h0123456 → bytes 0x30 0x3A 0x30 0x31 0x32 0x33 0x34 0x35 0x36 0x0D 0x0A. Every bit lasts exactly 4 cycles.
- Full scan: NUM_SEL=8, `SYS_leds`={19'b0, SYS_output_sel}. Each line shows its own index, e.g. line 5 is "5:0000005". `SYS_output_sel` stays stable from its SETTLE through CAPTURE.
- Hex range: `SYS_leds`=27'h7FFFFFF at sel 7 → "7:7FFFFFF", with 0x46 for each F.
- Handshake: `start` held high throughout → exactly one dump; `done` pulses once, after 8·(2+2+11·41) cycles. A second dump starts on the IDLE cycle after `done`.
- Checksum, with `DUMP_CHECKSUM_EN`: `SYS_leds`=27'h0123456 → line ends with bytes 0x20 0x37 0x30 0x0D 0x0A (" 70", since 0x00^0x12^0x34^0x56=0x70).
